multi_evt_counter: RTL and testbench

Parametrised, multi-channel successor to the single 16-bit event counter. Provides CHANNELS independent counters of WIDTH bits. Each counter has:
- per-channel up/down direction
- synchronous clear and load
- selectable wrap or saturate at a programmable limit
- terminal-count pulse and saturation flag

Sits between event sources (debounced buttons, timers, strobe generators) and display/logic consumers.

---
 rtl/multi_evt_counter.sv | 111 +++++++++++
 tb/tb_multi_evt_counter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_evt_counter.sv
// Multi-channel up/down event counter with wrap or saturate at MAX_COUNT.
// Define MULTI_EVT_COUNTER_EDGE_EN to count rising edges of evt_in instead of levels.
module multi_evt_counter #(
    parameter int unsigned      WIDTH     = 16,
    parameter int unsigned      CHANNELS  = 4,
    parameter logic [WIDTH-1:0] MAX_COUNT = {WIDTH{1'b1}},
    parameter bit               SATURATE  = 1'b0
) (
    input  logic                      clk_in,
    input  logic                      rst_n_in,
    input  logic [CHANNELS-1:0]       evt_in,
    input  logic [CHANNELS-1:0]       dir_in,
    input  logic [CHANNELS-1:0]       clr_in,
    input  logic [CHANNELS-1:0]       load_in,
    input  logic [WIDTH-1:0]          load_val_in,
    output logic [CHANNELS*WIDTH-1:0] count_out,
    output logic [CHANNELS-1:0]       tc_out,
    output logic [CHANNELS-1:0]       sat_out
);

    localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);
    localparam logic [WIDTH-1:0] MAX_M1 = MAX_COUNT - ONE;

    logic [CHANNELS-1:0] evt;
    logic [WIDTH-1:0]    load_clamped;

`ifdef MULTI_EVT_COUNTER_EDGE_EN
    logic [CHANNELS-1:0] evt_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            evt_q <= '0;
        end else begin
            evt_q <= evt_in;
        end
    end

    assign evt = evt_in & ~evt_q;
`else
    assign evt = evt_in;
`endif

    assign load_clamped = (load_val_in > MAX_COUNT) ? MAX_COUNT : load_val_in;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [WIDTH-1:0] cnt_q;
        logic [WIDTH-1:0] cnt_d;
        logic             tc_q;
        logic             tc_d;
        logic             sat_q;
        logic             sat_d;
        logic             at_max;
        logic             at_zero;

        assign at_max  = (cnt_q == MAX_COUNT);
        assign at_zero = (cnt_q == '0);

        always_comb begin
            cnt_d = cnt_q;
            tc_d  = 1'b0;
            if (clr_in[i]) begin
                cnt_d = '0;
            end else if (load_in[i]) begin
                cnt_d = load_clamped;
            end else if (evt[i]) begin
                if (dir_in[i]) begin
                    if (!at_max) begin
                        cnt_d = cnt_q + ONE;
                        tc_d  = SATURATE && (cnt_q == MAX_M1);
                    end else if (!SATURATE) begin
                        cnt_d = '0;
                        tc_d  = 1'b1;
                    end
                end else begin
                    if (!at_zero) begin
                        cnt_d = cnt_q - ONE;
                        tc_d  = SATURATE && (cnt_q == ONE);
                    end else if (!SATURATE) begin
                        cnt_d = MAX_COUNT;
                        tc_d  = 1'b1;
                    end
                end
            end
        end

        // Saturation flag tracks the limit in the direction just sampled.
        always_comb begin
            sat_d = 1'b0;
            if (SATURATE) begin
                sat_d = dir_in[i] ? (cnt_d == MAX_COUNT) : (cnt_d == '0);
            end
        end

        always_ff @(posedge clk_in or negedge rst_n_in) begin
            if (!rst_n_in) begin
                cnt_q <= '0;
                tc_q  <= 1'b0;
                sat_q <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                tc_q  <= tc_d;
                sat_q <= sat_d;
            end
        end

        assign count_out[i*WIDTH +: WIDTH] = cnt_q;
        assign tc_out[i]                   = tc_q;
        assign sat_out[i]                  = sat_q;
    end

endmodule

// File: tb/tb_multi_evt_counter.sv
// Bench for multi_evt_counter: three instances (default, wrap at 9, saturate at 9)
// share one stimulus stream and are checked each cycle against a counting model.
module tb_multi_evt_counter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  evt;
    logic [3:0]  dir;
    logic [3:0]  clr;
    logic [3:0]  load;
    logic [15:0] lv16;
    logic [3:0]  lv4;
    logic [63:0] cnt0;
    logic [15:0] cnt1;
    logic [15:0] cnt2;
    logic [3:0]  tc0, tc1, tc2;
    logic [3:0]  sat0, sat1, sat2;

    int checks = 0;
    int errors = 0;

    int mmax [3] = '{65535, 9, 9};
    bit msp  [3] = '{1'b0, 1'b0, 1'b1};
    int mcnt [3][4];
    bit mtc  [3][4];
    bit msat [3][4];
    bit mprev[4];

    assign lv4 = lv16[3:0];

    multi_evt_counter #(.WIDTH(16), .CHANNELS(4)) u_def (
        .clk_in(clk), .rst_n_in(rst_n), .evt_in(evt), .dir_in(dir),
        .clr_in(clr), .load_in(load), .load_val_in(lv16),
        .count_out(cnt0), .tc_out(tc0), .sat_out(sat0)
    );

    multi_evt_counter #(
        .WIDTH(4), .CHANNELS(4), .MAX_COUNT(4'd9), .SATURATE(1'b0)
    ) u_wrap (
        .clk_in(clk), .rst_n_in(rst_n), .evt_in(evt), .dir_in(dir),
        .clr_in(clr), .load_in(load), .load_val_in(lv4),
        .count_out(cnt1), .tc_out(tc1), .sat_out(sat1)
    );

    multi_evt_counter #(
        .WIDTH(4), .CHANNELS(4), .MAX_COUNT(4'd9), .SATURATE(1'b1)
    ) u_sat (
        .clk_in(clk), .rst_n_in(rst_n), .evt_in(evt), .dir_in(dir),
        .clr_in(clr), .load_in(load), .load_val_in(lv4),
        .count_out(cnt2), .tc_out(tc2), .sat_out(sat2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int d_cnt(int k, int i);
        case (k)
            0:       return int'(cnt0[i*16 +: 16]);
            1:       return int'(cnt1[i*4 +: 4]);
            default: return int'(cnt2[i*4 +: 4]);
        endcase
    endfunction

    function automatic int d_tc(int k, int i);
        case (k)
            0:       return int'(tc0[i]);
            1:       return int'(tc1[i]);
            default: return int'(tc2[i]);
        endcase
    endfunction

    function automatic int d_sat(int k, int i);
        case (k)
            0:       return int'(sat0[i]);
            1:       return int'(sat1[i]);
            default: return int'(sat2[i]);
        endcase
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Counting model: plain integer arithmetic on the rules.
    task automatic model_step(int k);
        for (int i = 0; i < 4; i++) begin
            int mx;
            int lv;
            bit ev;
            mx = mmax[k];
            lv = (k == 0) ? int'(lv16) : int'(lv4);
`ifdef MULTI_EVT_COUNTER_EDGE_EN
            ev = evt[i] && !mprev[i];
`else
            ev = evt[i];
`endif
            mtc[k][i] = 1'b0;
            if (clr[i]) begin
                mcnt[k][i] = 0;
            end else if (load[i]) begin
                mcnt[k][i] = (lv > mx) ? mx : lv;
            end else if (ev && dir[i]) begin
                if (mcnt[k][i] < mx) begin
                    mcnt[k][i] = mcnt[k][i] + 1;
                    mtc[k][i]  = msp[k] && (mcnt[k][i] == mx);
                end else if (!msp[k]) begin
                    mcnt[k][i] = 0;
                    mtc[k][i]  = 1'b1;
                end
            end else if (ev) begin
                if (mcnt[k][i] > 0) begin
                    mcnt[k][i] = mcnt[k][i] - 1;
                    mtc[k][i]  = msp[k] && (mcnt[k][i] == 0);
                end else if (!msp[k]) begin
                    mcnt[k][i] = mx;
                    mtc[k][i]  = 1'b1;
                end
            end
            msat[k][i] = msp[k] &&
                (dir[i] ? (mcnt[k][i] == mx) : (mcnt[k][i] == 0));
        end
    endtask

    always @(posedge clk) begin
        if (rst_n === 1'b1) begin
            for (int k = 0; k < 3; k++) model_step(k);
            for (int i = 0; i < 4; i++) mprev[i] = evt[i];
        end
    end

    always @(negedge rst_n) begin
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 4; i++) begin
                mcnt[k][i] = 0;
                mtc[k][i]  = 1'b0;
                msat[k][i] = 1'b0;
            end
        end
        for (int i = 0; i < 4; i++) mprev[i] = 1'b0;
    end

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("cnt k%0d ch%0d", k, i), d_cnt(k, i), mcnt[k][i]);
                chk($sformatf("tc k%0d ch%0d", k, i), d_tc(k, i), int'(mtc[k][i]));
                chk($sformatf("sat k%0d ch%0d", k, i), d_sat(k, i), int'(msat[k][i]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(logic [3:0] e, logic [3:0] d, logic [3:0] c,
                         logic [3:0] l, logic [15:0] v);
        evt  = e;
        dir  = d;
        clr  = c;
        load = l;
        lv16 = v;
    endtask

    int exp_a [4] = '{8, 9, 9, 9};
    int exp_t [4] = '{0, 1, 0, 0};
    int exp_s [4] = '{0, 1, 1, 1};
    int held;

    initial begin
        rst_n = 1'b0;
        drive(4'b0000, 4'b1111, 4'b0000, 4'b0000, 16'd0);
        tick();
        tick();
        chk("reset cnt", d_cnt(0, 0), 0);
        chk("reset tc", int'(tc2), 0);
        rst_n = 1'b1;

        // Level/edge counting on the default instance
        drive(4'b0001, 4'b1111, 4'b0000, 4'b0000, 16'd0);
        tick();
        chk("t1 first", d_cnt(0, 0), 1);
        evt = 4'b0000;
        tick();
        evt = 4'b0001;
        tick();
        tick();
        evt = 4'b0000;
        tick();
`ifdef MULTI_EVT_COUNTER_EDGE_EN
        chk("t1 second", d_cnt(0, 0), 2);
`else
        chk("t1 second", d_cnt(0, 0), 3);
`endif
        chk("t1 tc", int'(tc0), 0);
        chk("t1 sat", int'(sat0), 0);

        // Wrap up then down at 9
        drive(4'b0000, 4'b1111, 4'b0000, 4'b0001, 16'd9);
        tick();
        chk("t2 load", d_cnt(1, 0), 9);
        drive(4'b0001, 4'b1111, 4'b0000, 4'b0000, 16'd0);
        tick();
        chk("t2 wrap up", d_cnt(1, 0), 0);
        chk("t2 tc up", d_tc(1, 0), 1);
        evt = 4'b0000;
        tick();
        chk("t2 tc one cycle", d_tc(1, 0), 0);
        drive(4'b0001, 4'b1110, 4'b0000, 4'b0000, 16'd0);
        tick();
        chk("t2 wrap down", d_cnt(1, 0), 9);
        chk("t2 tc down", d_tc(1, 0), 1);
        evt = 4'b0000;
        tick();

        // Saturate at 9
        drive(4'b0000, 4'b1111, 4'b0000, 4'b0001, 16'd7);
        tick();
        load = 4'b0000;
        for (int j = 0; j < 4; j++) begin
            evt = 4'b0001;
            tick();
            chk($sformatf("t3 cnt %0d", j), d_cnt(2, 0), exp_a[j]);
            chk($sformatf("t3 tc %0d", j), d_tc(2, 0), exp_t[j]);
            chk($sformatf("t3 sat %0d", j), d_sat(2, 0), exp_s[j]);
            evt = 4'b0000;
            tick();
        end
        dir = 4'b1110;
        tick();
        chk("t3 sat drop", d_sat(2, 0), 0);

        // Priority and clamp
        drive(4'b0001, 4'b1111, 4'b0001, 4'b0001, 16'd5);
        tick();
        for (int k = 0; k < 3; k++) chk("t4 clr wins", d_cnt(k, 0), 0);
        drive(4'b0000, 4'b1111, 4'b0000, 4'b0001, 16'd15);
        tick();
        chk("t4 clamp wrap", d_cnt(1, 0), 9);
        chk("t4 clamp sat", d_cnt(2, 0), 9);
        chk("t4 no clamp", d_cnt(0, 0), 15);
        drive(4'b0001, 4'b1111, 4'b0000, 4'b0001, 16'd3);
        tick();
        for (int k = 0; k < 3; k++) chk("t4 load wins", d_cnt(k, 0), 3);
        drive(4'b0000, 4'b1111, 4'b0000, 4'b0000, 16'd0);
        tick();

        // Channel independence
        drive(4'b0000, 4'b1111, 4'b0001, 4'b0110, 16'd5);
        tick();
        drive(4'b0011, 4'b0001, 4'b0100, 4'b0000, 16'd0);
        tick();
        for (int k = 0; k < 3; k++) begin
            chk("t5 ch0 up", d_cnt(k, 0), 1);
            chk("t5 ch1 down", d_cnt(k, 1), 4);
            chk("t5 ch2 clr", d_cnt(k, 2), 0);
            chk("t5 ch3 idle", d_cnt(k, 3), 0);
        end

        // Held level, then async reset mid-cycle
        drive(4'b0000, 4'b1111, 4'b0001, 4'b0000, 16'd0);
        tick();
        drive(4'b0001, 4'b1111, 4'b0000, 4'b0000, 16'd0);
        for (int j = 0; j < 5; j++) tick();
        evt = 4'b0000;
        tick();
        evt = 4'b0001;
        tick();
        evt = 4'b0000;
        tick();
`ifdef MULTI_EVT_COUNTER_EDGE_EN
        held = 2;
`else
        held = 6;
`endif
        for (int k = 0; k < 3; k++) chk("t6 held", d_cnt(k, 0), held);
        #1;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 4; i++) chk("t6 async rst", d_cnt(k, i), 0);
        end
        evt = 4'b0001;
        #3;
        rst_n = 1'b1;
        tick();
        tick();
        tick();
`ifdef MULTI_EVT_COUNTER_EDGE_EN
        chk("t6 high at release", d_cnt(0, 0), 1);
`else
        chk("t6 high at release", d_cnt(0, 0), 3);
`endif

        // Mixed traffic, model-checked each cycle
        for (int j = 0; j < 80; j++) begin
            drive(4'($urandom), 4'($urandom),
                  ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'b0000,
                  ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000,
                  16'($urandom));
            tick();
        end
        drive(4'b0000, 4'b1111, 4'b0000, 4'b0000, 16'd0);
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
